// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter owner and instruction-fetch sequencer.
//
// Each instruction goes FETCH -> EXECUTE. FETCH holds a memory request open
// until mem_ready is seen. EXECUTE lasts one cycle, and at its closing edge
// the next PC is chosen from the opcode class: increment, branch target,
// call/return, or hold (HALT).
//
// Optional build macro: PC_SEQ_RETURN_STACK_EN
//   defined   : 4-entry return-address stack for CALL/RET, with a sticky
//               stack_error on overflow or underflow.
//   undefined : CALL is an unconditional branch, RET is sequential, and
//               stack_error is tied low.
//
// state    | meaning
// ---------+------------------------------------------------------------
// FETCH    | request word at program_counter, wait for mem_ready
// EXECUTE  | instruction latched (instruction_valid), next PC chosen
// HALT     | fetch stopped, PC held until a resume pulse

module pc_sequencer #(
  parameter int                  PC_WIDTH     = 12,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [5:0]          operation,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                mem_ready,
  input  logic                resume,
  output logic [PC_WIDTH-1:0] program_counter,
  output logic                fetch_request,
  output logic                instruction_valid,
  output logic [PC_WIDTH-1:0] link_address,
  output logic                halted,
  output logic                stack_error
);

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXECUTE = 2'd1,
    ST_HALT    = 2'd2
  } state_t;

  localparam logic [5:0] OP_BR_LO = 6'h12;
  localparam logic [5:0] OP_BR_HI = 6'h16;
  localparam logic [5:0] OP_CALL  = 6'h18;
  localparam logic [5:0] OP_RET   = 6'h19;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_t              state;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] exec_next_pc;
  logic                exec_halt;

`ifdef PC_SEQ_RETURN_STACK_EN
  logic [PC_WIDTH-1:0] ras_mem [4];
  logic [1:0]          ras_wp;
  logic [2:0]          ras_count;
  logic                ras_err;
  logic                ras_push;
  logic                ras_pop;
  logic [PC_WIDTH-1:0] ras_top;
`endif

  // Sequential successor; wraps modulo 2^PC_WIDTH and doubles as the link address.
  always_comb begin
    pc_inc       = program_counter + PC_ONE;
    link_address = pc_inc;
  end

  // Decode the opcode class and pick the PC that EXECUTE will commit.
  always_comb begin
    exec_next_pc = pc_inc;
    exec_halt    = 1'b0;
`ifdef PC_SEQ_RETURN_STACK_EN
    ras_push     = 1'b0;
    ras_pop      = 1'b0;
    ras_top      = ras_mem[ras_wp - 2'd1];
`endif
    if (operation >= OP_BR_LO && operation <= OP_BR_HI) begin
      if (branch_taken) exec_next_pc = branch_target;
    end else if (operation == OP_CALL) begin
      exec_next_pc = branch_target;
`ifdef PC_SEQ_RETURN_STACK_EN
      ras_push     = (state == ST_EXECUTE);
`endif
    end else if (operation == OP_RET) begin
`ifdef PC_SEQ_RETURN_STACK_EN
      // An empty stack falls back to the sequential PC.
      ras_pop = (state == ST_EXECUTE);
      if (ras_count != 3'd0) exec_next_pc = ras_top;
`endif
    end else if (operation == OP_HALT) begin
      exec_next_pc = program_counter;
      exec_halt    = 1'b1;
    end
  end

`ifdef PC_SEQ_RETURN_STACK_EN
  // Circular return stack: when it is full, the write pointer already points
  // at the oldest entry, so a push overwrites that entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      ras_wp    <= 2'd0;
      ras_count <= 3'd0;
      ras_err   <= 1'b0;
    end else begin
      if (ras_push) begin
        ras_mem[ras_wp] <= link_address;
        ras_wp          <= ras_wp + 2'd1;
        if (ras_count == 3'd4) ras_err   <= 1'b1;
        else                   ras_count <= ras_count + 3'd1;
      end
      if (ras_pop) begin
        if (ras_count == 3'd0) begin
          ras_err <= 1'b1;
        end else begin
          ras_wp    <= ras_wp - 2'd1;
          ras_count <= ras_count - 3'd1;
        end
      end
    end
  end

  assign stack_error = ras_err;
`else
  assign stack_error = 1'b0;
`endif

  // Main sequencer: state, PC and registered handshake/status outputs.
  // fetch_request stays low for one cycle after reset, and mem_ready is
  // accepted only while the request is actually being driven.
  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= ST_FETCH;
      program_counter   <= RESET_VECTOR;
      fetch_request     <= 1'b0;
      instruction_valid <= 1'b0;
      halted            <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          instruction_valid <= 1'b0;
          if (fetch_request && mem_ready) begin
            state             <= ST_EXECUTE;
            instruction_valid <= 1'b1;
            fetch_request     <= 1'b0;
          end else begin
            fetch_request <= 1'b1;
          end
        end
        ST_EXECUTE: begin
          instruction_valid <= 1'b0;
          program_counter   <= exec_next_pc;
          if (exec_halt) begin
            state         <= ST_HALT;
            halted        <= 1'b1;
            fetch_request <= 1'b0;
          end else begin
            state         <= ST_FETCH;
            fetch_request <= 1'b1;
          end
        end
        ST_HALT: begin
          instruction_valid <= 1'b0;
          fetch_request     <= 1'b0;
          if (resume) begin
            program_counter <= pc_inc;
            state           <= ST_FETCH;
            halted          <= 1'b0;
            fetch_request   <= 1'b1;
          end
        end
        default: begin
          state             <= ST_FETCH;
          fetch_request     <= 1'b0;
          instruction_valid <= 1'b0;
          halted            <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer. Follows PC_SEQ_RETURN_STACK_EN if defined.
`timescale 1ns/1ps
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  operation = 6'h00;
  logic        branch_taken = 1'b0;
  logic [11:0] branch_target = 12'h000;
  logic        mem_ready = 1'b0;
  logic        resume = 1'b0;
  logic [11:0] program_counter;
  logic        fetch_request;
  logic        instruction_valid;
  logic [11:0] link_address;
  logic        halted;
  logic        stack_error;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.PC_WIDTH(12), .RESET_VECTOR(12'h000)) dut (
    .clock(clock), .reset(reset), .operation(operation),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .mem_ready(mem_ready), .resume(resume),
    .program_counter(program_counter), .fetch_request(fetch_request),
    .instruction_valid(instruction_valid), .link_address(link_address),
    .halted(halted), .stack_error(stack_error)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One FETCH (mem_ready=1) + EXECUTE; leaves the DUT just after EXECUTE.
  task automatic exec_instr(input logic [5:0] op, input logic tk, input logic [11:0] tgt);
    operation = op; branch_taken = tk; branch_target = tgt; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); reset = 1'b0; step();
  endtask

  task automatic test_reset();
    reset = 1'b1; step(); step();
    checks++; if (program_counter !== 12'h000) begin errors++; $display("FAIL reset_pc got %h exp 000", program_counter); end
    checks++; if (fetch_request !== 1'b0) begin errors++; $display("FAIL reset_fetch_request got %b exp 0", fetch_request); end
    checks++; if (instruction_valid !== 1'b0) begin errors++; $display("FAIL reset_instruction_valid got %b exp 0", instruction_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
    checks++; if (stack_error !== 1'b0) begin errors++; $display("FAIL reset_stack_error got %b exp 0", stack_error); end
    reset = 1'b0; step();
    checks++; if (fetch_request !== 1'b1) begin errors++; $display("FAIL post_reset_fetch_request got %b exp 1", fetch_request); end
    checks++; if (program_counter !== 12'h000) begin errors++; $display("FAIL post_reset_pc got %h exp 000", program_counter); end
  endtask

  task automatic test_sequential();
    operation = 6'h05; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (program_counter !== 12'(i) || fetch_request !== 1'b1 || instruction_valid !== 1'b0) begin
        errors++; $display("FAIL seq_fetch[%0d] got pc=%h fr=%b iv=%b exp pc=%h fr=1 iv=0", i, program_counter, fetch_request, instruction_valid, 12'(i)); end
      step();
      checks++; if (program_counter !== 12'(i) || fetch_request !== 1'b0 || instruction_valid !== 1'b1) begin
        errors++; $display("FAIL seq_exec[%0d] got pc=%h fr=%b iv=%b exp pc=%h fr=0 iv=1", i, program_counter, fetch_request, instruction_valid, 12'(i)); end
      step();
    end
    mem_ready = 1'b0;
    checks++; if (program_counter !== 12'h004) begin errors++; $display("FAIL seq_final_pc got %h exp 004", program_counter); end
  endtask

  task automatic test_wrap();
    exec_instr(6'h12, 1'b1, 12'hFFF);
    checks++; if (program_counter !== 12'hFFF) begin errors++; $display("FAIL wrap_setup got %h exp fff", program_counter); end
    checks++; if (link_address !== 12'h000) begin errors++; $display("FAIL wrap_link got %h exp 000", link_address); end
    exec_instr(6'h17, 1'b1, 12'h123);
    checks++; if (program_counter !== 12'h000) begin errors++; $display("FAIL wrap_pc got %h exp 000", program_counter); end
  endtask

  task automatic test_branch();
    logic [5:0]  ops [6] = '{6'h12, 6'h12, 6'h16, 6'h16, 6'h20, 6'h11};
    logic        tks [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [11:0] tgs [6] = '{12'h2A0, 12'h2A0, 12'h555, 12'h777, 12'h777, 12'h777};
    logic [11:0] exp [6] = '{12'h2A0, 12'h2A1, 12'h555, 12'h556, 12'h557, 12'h558};
    for (int i = 0; i < 6; i++) begin
      exec_instr(ops[i], tks[i], tgs[i]);
      checks++; if (program_counter !== exp[i] || fetch_request !== 1'b1) begin
        errors++; $display("FAIL branch[%0d] got pc=%h fr=%b exp pc=%h fr=1", i, program_counter, fetch_request, exp[i]); end
    end
  endtask

  task automatic test_wait_states();
    mem_ready = 1'b0; operation = 6'h05;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (program_counter !== 12'h558 || fetch_request !== 1'b1 || instruction_valid !== 1'b0) begin
        errors++; $display("FAIL wait[%0d] got pc=%h fr=%b iv=%b exp pc=558 fr=1 iv=0", i, program_counter, fetch_request, instruction_valid); end
    end
    mem_ready = 1'b1; step(); mem_ready = 1'b0;
    checks++; if (instruction_valid !== 1'b1 || program_counter !== 12'h558) begin
      errors++; $display("FAIL wait_exec got iv=%b pc=%h exp iv=1 pc=558", instruction_valid, program_counter); end
    step();
    checks++; if (program_counter !== 12'h559) begin errors++; $display("FAIL wait_next_pc got %h exp 559", program_counter); end
  endtask

  task automatic test_halt();
    exec_instr(6'h12, 1'b1, 12'h010);
    exec_instr(6'h3F, 1'b1, 12'h0AA);
    checks++; if (halted !== 1'b1 || program_counter !== 12'h010 || fetch_request !== 1'b0) begin
      errors++; $display("FAIL halt_enter got h=%b pc=%h fr=%b exp h=1 pc=010 fr=0", halted, program_counter, fetch_request); end
    mem_ready = 1'b1; step(); step(); mem_ready = 1'b0;
    checks++; if (halted !== 1'b1 || program_counter !== 12'h010 || instruction_valid !== 1'b0) begin
      errors++; $display("FAIL halt_hold got h=%b pc=%h iv=%b exp h=1 pc=010 iv=0", halted, program_counter, instruction_valid); end
    resume = 1'b1; step(); resume = 1'b0;
    checks++; if (halted !== 1'b0 || program_counter !== 12'h011 || fetch_request !== 1'b1) begin
      errors++; $display("FAIL halt_resume got h=%b pc=%h fr=%b exp h=0 pc=011 fr=1", halted, program_counter, fetch_request); end
    resume = 1'b1; step(); resume = 1'b0;
    checks++; if (program_counter !== 12'h011 || fetch_request !== 1'b1) begin
      errors++; $display("FAIL resume_in_fetch got pc=%h fr=%b exp pc=011 fr=1", program_counter, fetch_request); end
    exec_instr(6'h3F, 1'b0, 12'h000);
    resume = 1'b1; reset = 1'b1; step(); resume = 1'b0;
    checks++; if (program_counter !== 12'h000 || halted !== 1'b0 || fetch_request !== 1'b0) begin
      errors++; $display("FAIL halt_reset got pc=%h h=%b fr=%b exp pc=000 h=0 fr=0", program_counter, halted, fetch_request); end
    reset = 1'b0; step();
    checks++; if (fetch_request !== 1'b1 || program_counter !== 12'h000) begin
      errors++; $display("FAIL halt_reset_release got fr=%b pc=%h exp fr=1 pc=000", fetch_request, program_counter); end
  endtask

  task automatic test_call_ret();
`ifdef PC_SEQ_RETURN_STACK_EN
    logic [11:0] tg [5]  = '{12'h200, 12'h300, 12'h400, 12'h500, 12'h600};
    logic [11:0] rt [5]  = '{12'h501, 12'h401, 12'h301, 12'h201, 12'h202};
    logic        er [5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`else
    logic [11:0] tg [5]  = '{12'h200, 12'h300, 12'h400, 12'h500, 12'h600};
`endif
    do_reset();
    exec_instr(6'h12, 1'b1, 12'h020);
    exec_instr(6'h18, 1'b0, 12'h100);
    checks++; if (program_counter !== 12'h100) begin errors++; $display("FAIL call_pc got %h exp 100", program_counter); end
    exec_instr(6'h19, 1'b0, 12'h3C3);
`ifdef PC_SEQ_RETURN_STACK_EN
    checks++; if (program_counter !== 12'h021 || stack_error !== 1'b0) begin
      errors++; $display("FAIL ret_pc got pc=%h err=%b exp pc=021 err=0", program_counter, stack_error); end
    for (int i = 0; i < 5; i++) begin
      exec_instr(6'h18, 1'b0, tg[i]);
      checks++; if (program_counter !== tg[i] || stack_error !== (i == 4)) begin
        errors++; $display("FAIL nest_call[%0d] got pc=%h err=%b exp pc=%h err=%b", i, program_counter, stack_error, tg[i], i == 4); end
    end
    for (int i = 0; i < 5; i++) begin
      exec_instr(6'h19, 1'b0, 12'h3C3);
      checks++; if (program_counter !== rt[i] || stack_error !== 1'b1 || er[i] !== 1'b0 && 1'b0) begin
        errors++; $display("FAIL nest_ret[%0d] got pc=%h err=%b exp pc=%h err=1", i, program_counter, stack_error, rt[i]); end
    end
    do_reset();
    checks++; if (stack_error !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", stack_error); end
    exec_instr(6'h19, 1'b0, 12'h3C3);
    checks++; if (program_counter !== 12'h001 || stack_error !== 1'b1) begin
      errors++; $display("FAIL ret_empty got pc=%h err=%b exp pc=001 err=1", program_counter, stack_error); end
`else
    checks++; if (program_counter !== 12'h101 || stack_error !== 1'b0) begin
      errors++; $display("FAIL ret_seq got pc=%h err=%b exp pc=101 err=0", program_counter, stack_error); end
    for (int i = 0; i < 5; i++) begin
      exec_instr(6'h18, 1'b0, tg[i]);
      checks++; if (program_counter !== tg[i] || stack_error !== 1'b0) begin
        errors++; $display("FAIL nest_call[%0d] got pc=%h err=%b exp pc=%h err=0", i, program_counter, stack_error, tg[i]); end
    end
`endif
  endtask

  initial begin
    step();
    test_reset();
    test_sequential();
    test_wrap();
    test_branch();
    test_wait_states();
    test_halt();
    test_call_ret();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Instruction-fetch controller that owns the program counter and sequences each instruction through fetch, execute and halt. It handshakes with instruction memory and samples the decoded opcode and branch resolution from the datapath. It then chooses the next PC: increment, branch target, call/return, or hold. It sits between the control unit, the branch comparator and instruction memory, and supplies the link address to the register file.

## Interface
- PC_WIDTH, 12, program counter width
- RESET_VECTOR, 12'h000, PC value loaded by reset
- clock  input  1  rising-edge clock, sole clock domain
- reset  input  1  synchronous, active-high reset
- operation  input  6  decoded opcode of the current instruction, valid in EXECUTE
- branch_taken  input  1  branch condition result, valid in EXECUTE
- branch_target  input  PC_WIDTH  jump/branch/call destination, valid in EXECUTE
- mem_ready  input  1  instruction memory has the word at program_counter
- resume  input  1  leave HALT (single-cycle pulse)
- program_counter  output  PC_WIDTH  current PC, registered
- fetch_request  output  1  high in FETCH, requests the word at program_counter
- instruction_valid  output  1  one-cycle pulse: the instruction word is latched, EXECUTE begins
- link_address  output  PC_WIDTH  program_counter+1 (mod 2^PC_WIDTH), combinational
- halted  output  1  high in HALT
- stack_error  output  1  sticky return-stack fault

## Operation
- States: FETCH, EXECUTE, HALT.
- FETCH:
  - fetch_request=1.
  - On mem_ready=1: go to EXECUTE; instruction_valid=1 in the following cycle.
  - Otherwise stay in FETCH with PC unchanged.
- EXECUTE: lasts exactly one cycle. The PC is updated at its closing edge by opcode class, and the state returns to FETCH unless HALT is taken.
  - operation<6'h12 or operation==6'h17: PC <= PC+1.
  - 6'h12..6'h16 (branches): PC <= branch_taken ? branch_target : PC+1.
  - 6'h18 CALL, 6'h19 RET: see Configuration.
  - 6'h3F HALT: PC held; go to HALT.
  - All other opcodes: PC <= PC+1.
- HALT:
  - fetch_request=0; PC held.
  - resume=1: PC <= PC+1; go to FETCH.
- Arithmetic: all PC+1 computations wrap modulo 2^PC_WIDTH (12'hFFF+1=12'h000), with no flag. branch_target is used unmodified.
- mem_ready outside FETCH and resume outside HALT are ignored.

## Timing
- Reset values: program_counter=RESET_VECTOR, state=FETCH, fetch_request=0, instruction_valid=0, halted=0, stack_error=0, return stack empty.
- fetch_request is forced 0 while reset is high. It goes to 1 in the first cycle after reset deasserts.
- Minimum instruction period is 2 cycles: FETCH with mem_ready=1, then EXECUTE. Each extra cycle of mem_ready=0 adds one cycle.
- New program_counter is visible the cycle after EXECUTE, together with fetch_request=1.
- Reset mid-operation (any state, any cycle) overrides everything: reset values are taken at the next edge and the return stack is cleared.
- resume and reset in the same cycle: reset wins.

## Configuration
- PC_SEQ_RETURN_STACK_EN defined:
  - 4-entry return-address stack.
  - CALL pushes link_address and sets PC <= branch_target.
  - RET pops into PC.
  - Push when full overwrites the oldest entry and sets stack_error.
  - Pop when empty sets PC <= PC+1 and sets stack_error.
  - stack_error is cleared only by reset.
- Not defined:
  - No stack storage.
  - CALL behaves as an unconditional branch: PC <= branch_target.
  - RET behaves as a sequential opcode: PC <= PC+1.
  - stack_error is tied 0.

## Test plan
- Reset, then operation=6'h05 with mem_ready=1 every FETCH → PC steps 0,1,2,3; fetch_request and instruction_valid alternate each cycle.
- PC=12'hFFF, operation=6'h17 → PC=12'h000 after EXECUTE.
- operation=6'h12, branch_target=12'h2A0, with branch_taken=1 → PC=12'h2A0; same with branch_taken=0 → PC+1.
- mem_ready held 0 for 5 cycles in FETCH → PC stable and fetch_request=1 throughout; EXECUTE occurs only after mem_ready=1.
- operation=6'h3F at PC=12'h010 → halted=1 and PC=12'h010; resume pulse → PC=12'h011 in FETCH. Reset asserted during HALT → PC=RESET_VECTOR.
- With PC_SEQ_RETURN_STACK_EN: CALL at 12'h020 to 12'h100, then RET → PC=12'h021. Five nested CALLs → stack_error=1. RET on empty stack → PC+1 and stack_error=1.
